// File: rtl/nibble_serial_pkg.sv
// Shared constants, FSM state type and sizing helper for the nibble-serial adder.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nibble counter width; a single-nibble operand still needs one bit.
    function automatic int count_width(input int width);
        int n;
        n = $clog2(width / NIBBLE_W);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/carry_select_4bit.sv
// 4-bit carry-select adder cell: both carry-in cases ripple in parallel, cin picks one.
module carry_select_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c0;
    logic [4:0] c1;
    logic [3:0] s0;
    logic [3:0] s1;

    assign c0[0] = 1'b0;
    assign c1[0] = 1'b1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
        assign s0[gi]    = a[gi] ^ b[gi] ^ c0[gi];
        assign c0[gi+1]  = (a[gi] & b[gi]) | (c0[gi] & (a[gi] ^ b[gi]));
        assign s1[gi]    = a[gi] ^ b[gi] ^ c1[gi];
        assign c1[gi+1]  = (a[gi] & b[gi]) | (c1[gi] & (a[gi] ^ b[gi]));
    end

    assign sum  = cin ? s1 : s0;
    assign cout = cin ? c1[4] : c0[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Streams WIDTH-bit operands through one 4-bit carry-select cell, one nibble per cycle.
// Optional signed-overflow output enabled by defining NIBBLE_SERIAL_OVF_EN.
import nibble_serial_pkg::*;

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NIBBLE_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = count_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t             state_reg;
    logic [WIDTH-1:0]   a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic [WIDTH-1:0]   sum_next;
    logic [CNT_W-1:0]   count_reg;
    logic               carry_reg;
    logic               cout_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [NIBBLE_W-1:0] nib_sum;
    logic               nib_cout;
`ifdef NIBBLE_SERIAL_OVF_EN
    logic               a_sign_reg;
    logic               b_sign_reg;
    logic               ovf_reg;
`endif

    carry_select_4bit u_nibble (
        .a    (a_sh_reg[NIBBLE_W-1:0]),
        .b    (b_sh_reg[NIBBLE_W-1:0]),
        .cin  (carry_reg),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // New nibble enters at the top; after NIBBLES shifts the sum is fully aligned.
    if (WIDTH == NIBBLE_W) begin : g_single
        assign sum_next = nib_sum;
    end else begin : g_multi
        assign sum_next = {nib_sum, sum_reg[WIDTH-1:NIBBLE_W]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            sum_reg       <= '0;
            count_reg     <= '0;
            carry_reg     <= 1'b0;
            cout_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
            a_sign_reg    <= 1'b0;
            b_sign_reg    <= 1'b0;
            ovf_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        a_sh_reg     <= a;
                        b_sh_reg     <= b;
                        carry_reg    <= cin;
                        count_reg    <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
`ifdef NIBBLE_SERIAL_OVF_EN
                        a_sign_reg   <= a[WIDTH-1];
                        b_sign_reg   <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sh_reg  <= a_sh_reg >> NIBBLE_W;
                    b_sh_reg  <= b_sh_reg >> NIBBLE_W;
                    sum_reg   <= sum_next;
                    carry_reg <= nib_cout;
                    count_reg <= count_reg + CNT_W'(1);
                    if (count_reg == LAST) begin
                        state_reg     <= DONE;
                        cout_reg      <= nib_cout;
                        out_valid_reg <= 1'b1;
`ifdef NIBBLE_SERIAL_OVF_EN
                        // Final nibble's bit 3 is the sum sign bit.
                        ovf_reg <= (a_sign_reg == b_sign_reg) && (nib_sum[NIBBLE_W-1] != a_sign_reg);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
`ifdef NIBBLE_SERIAL_OVF_EN
    assign ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and back-to-back checks of nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, cin16, cout16;
    logic [15:0] a16, b16, sum16;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4;
    logic [3:0]  a4, b4, sum4;
`ifdef NIBBLE_SERIAL_OVF_EN
    logic        ovf16, ovf4;
`endif

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16)
`ifdef NIBBLE_SERIAL_OVF_EN
        , .ovf(ovf16)
`endif
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4)
`ifdef NIBBLE_SERIAL_OVF_EN
        , .ovf(ovf4)
`endif
    );

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int total = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic run16(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         output logic [15:0] s, output logic co, output logic ov, output int lat);
        int n;
        n = 0;
        while (!in_ready16 && n < 20) begin tick; n++; end
        a16 = va; b16 = vb; cin16 = vc; in_valid16 = 1'b1;
        tick;
        in_valid16 = 1'b0; a16 = ~va; b16 = ~vb; cin16 = ~vc;
        lat = 0;
        while (!out_valid16 && lat < 50) begin tick; lat++; end
        s  = sum16;
        co = cout16;
        ov = 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
        ov = ovf16;
`endif
        $display("op16 a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d", va, vb, vc, s, co, lat);
        out_ready16 = 1'b1;
        tick;
        out_ready16 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        logic        co, ov;
        int          lat, n, last, acc;
        logic [15:0] ea, eb;
        logic [3:0]  fa, fb;
        logic        ec;
        logic [16:0] e17;
        logic [4:0]  e5;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid16 = 0; out_ready16 = 0; a16 = 0; b16 = 0; cin16 = 0;
        in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; cin4 = 0;
        repeat (2) tick;
        chk("reset in_ready", 32'(in_ready16), 32'd1);
        chk("reset out_valid", 32'(out_valid16), 32'd0);
        chk("reset sum", 32'(sum16), 32'd0);
        chk("reset cout", 32'(cout16), 32'd0);
        chk("reset in_ready w4", 32'(in_ready4), 32'd1);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 7; i++) begin
            run16(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov, lat);
            chk($sformatf("vec%0d sum", i), 32'(s), 32'(vecs[i].sum));
            chk($sformatf("vec%0d cout", i), 32'(co), 32'(vecs[i].cout));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
`ifdef NIBBLE_SERIAL_OVF_EN
            chk($sformatf("vec%0d ovf", i), 32'(ov), 32'(vecs[i].ovf));
`endif
        end

        // Backpressure: result must hold while the consumer stalls.
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 0; in_valid16 = 1'b1;
        tick;
        in_valid16 = 1'b0;
        n = 0;
        while (!out_valid16 && n < 50) begin tick; n++; end
        a16 = 16'hFFFF; b16 = 16'hFFFF; in_valid16 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            $display("stall cycle %0d sum=%h out_valid=%0d in_ready=%0d", k, sum16, out_valid16, in_ready16);
            chk("stall sum", 32'(sum16), 32'h3333);
            chk("stall cout", 32'(cout16), 32'd0);
            chk("stall out_valid", 32'(out_valid16), 32'd1);
            chk("stall in_ready", 32'(in_ready16), 32'd0);
        end
        in_valid16 = 1'b0; out_ready16 = 1'b1;
        tick;
        out_ready16 = 1'b0;
        chk("release out_valid", 32'(out_valid16), 32'd0);
        chk("release in_ready", 32'(in_ready16), 32'd1);
        tick;
        chk("idle stays idle", 32'(in_ready16), 32'd1);

        // Reset in the middle of a RUN.
        a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 0; in_valid16 = 1'b1;
        tick;
        in_valid16 = 1'b0;
        repeat (2) tick;
        rst_n = 1'b0;
        tick;
        $display("mid-run reset sum=%h cout=%0d out_valid=%0d in_ready=%0d", sum16, cout16, out_valid16, in_ready16);
        chk("abort sum", 32'(sum16), 32'd0);
        chk("abort cout", 32'(cout16), 32'd0);
        chk("abort out_valid", 32'(out_valid16), 32'd0);
        chk("abort in_ready", 32'(in_ready16), 32'd1);
`ifdef NIBBLE_SERIAL_OVF_EN
        chk("abort ovf", 32'(ovf16), 32'd0);
`endif
        rst_n = 1'b1;
        tick;
        run16(16'h00FF, 16'h0001, 1'b0, s, co, ov, lat);
        chk("post-reset sum", 32'(s), 32'h0100);
        chk("post-reset cout", 32'(co), 32'd0);

        // Back-to-back, WIDTH=16.
        in_valid16 = 1'b1; out_ready16 = 1'b1; last = -1;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!in_ready16 && n < 20) begin tick; n++; end
            ea = 16'($urandom); eb = 16'($urandom); ec = 1'($urandom);
            a16 = ea; b16 = eb; cin16 = ec;
            tick;
            acc = cycle;
            if (last >= 0) chk("b2b16 interval", 32'(acc - last), 32'd6);
            last = acc;
            a16 = 16'($urandom); b16 = 16'($urandom);
            n = 0;
            while (!out_valid16 && n < 20) begin tick; n++; end
            e17 = {1'b0, ea} + {1'b0, eb} + 17'(ec);
            $display("b2b16 a=%h b=%h cin=%0d -> sum=%h cout=%0d", ea, eb, ec, sum16, cout16);
            chk("b2b16 sum", 32'(sum16), 32'(e17[15:0]));
            chk("b2b16 cout", 32'(cout16), 32'(e17[16]));
`ifdef NIBBLE_SERIAL_OVF_EN
            chk("b2b16 ovf", 32'(ovf16), 32'((ea[15] == eb[15]) && (e17[15] != ea[15])));
`endif
        end
        in_valid16 = 1'b0;

        // Back-to-back, WIDTH=4.
        in_valid4 = 1'b1; out_ready4 = 1'b1; last = -1;
        for (int k = 0; k < 10; k++) begin
            n = 0;
            while (!in_ready4 && n < 20) begin tick; n++; end
            fa = 4'($urandom); fb = 4'($urandom); ec = 1'($urandom);
            a4 = fa; b4 = fb; cin4 = ec;
            tick;
            acc = cycle;
            if (last >= 0) chk("b2b4 interval", 32'(acc - last), 32'd3);
            last = acc;
            a4 = 4'($urandom); b4 = 4'($urandom);
            n = 0;
            while (!out_valid4 && n < 20) begin tick; n++; end
            e5 = {1'b0, fa} + {1'b0, fb} + 5'(ec);
            $display("b2b4 a=%h b=%h cin=%0d -> sum=%h cout=%0d", fa, fb, ec, sum4, cout4);
            chk("b2b4 sum", 32'(sum4), 32'(e5[3:0]));
            chk("b2b4 cout", 32'(cout4), 32'(e5[4]));
`ifdef NIBBLE_SERIAL_OVF_EN
            chk("b2b4 ovf", 32'(ovf4), 32'((fa[3] == fb[3]) && (e5[3] != fa[3])));
`endif
        end
        in_valid4 = 1'b0;
        repeat (4) tick;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
